// File: rtl/arith_result_acc_pkg.sv
// arith_result_acc_pkg: shared result width and FSM state encodings for the
// arithmetic_op result accumulator.
`default_nettype none

package arith_result_acc_pkg;

  localparam int ARITH_RES_W = 5;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arith_sum5.sv
// arith_sum5: combinational 5-input unsigned adder, widened by 3 bits so the
// sum of five RES_W operands never loses a carry.
`default_nettype none

module arith_sum5
  import arith_result_acc_pkg::*;
#(
  parameter int RES_W = ARITH_RES_W
) (
  input  logic [RES_W-1:0] a_i,
  input  logic [RES_W-1:0] b_i,
  input  logic [RES_W-1:0] c_i,
  input  logic [RES_W-1:0] d_i,
  input  logic [RES_W-1:0] e_i,
  output logic [RES_W+2:0] sum_o
);

  assign sum_o = (RES_W+3)'(a_i) + (RES_W+3)'(b_i) + (RES_W+3)'(c_i)
               + (RES_W+3)'(d_i) + (RES_W+3)'(e_i);

endmodule

`default_nettype wire

// File: rtl/arith_result_acc.sv
// arith_result_acc: accumulates x+y+u+z+v and max(x) over BLOCK_LEN samples and
// emits a held block summary. Define ACC_SAT_EN to saturate instead of wrap.
`default_nettype none

module arith_result_acc
  import arith_result_acc_pkg::*;
#(
  parameter int RES_W     = ARITH_RES_W,
  parameter int ACC_W     = 12,
  parameter int BLOCK_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] x,
  input  logic [RES_W-1:0] y,
  input  logic [RES_W-1:0] u,
  input  logic [RES_W-1:0] z,
  input  logic [RES_W-1:0] v,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] res_sum,
  output logic [RES_W-1:0] res_max,
  output logic             res_ovf
);

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] max_q, max_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] res_sum_q, res_sum_d;
  logic [RES_W-1:0] res_max_q, res_max_d;
  logic             res_ovf_q, res_ovf_d;

  logic [RES_W+2:0] sample_sum;
  logic [ACC_W:0]   acc_add;
  logic [ACC_W-1:0] acc_next;
  logic [RES_W-1:0] max_next;
  logic             step_ovf;
  logic             accept;
  logic             last;

  arith_sum5 #(.RES_W(RES_W)) u_sum5 (
    .a_i   (x),
    .b_i   (y),
    .c_i   (u),
    .d_i   (z),
    .e_i   (v),
    .sum_o (sample_sum)
  );

  // The extra top bit of acc_add is the overflow indicator for this sample.
  assign acc_add  = {1'b0, acc_q} + (ACC_W+1)'(sample_sum);
  assign step_ovf = acc_add[ACC_W];
`ifdef ACC_SAT_EN
  assign acc_next = step_ovf ? {ACC_W{1'b1}} : acc_add[ACC_W-1:0];
`else
  assign acc_next = acc_add[ACC_W-1:0];
`endif
  assign max_next = (x > max_q) ? x : max_q;
  assign last     = (cnt_q == CNT_W'(BLOCK_LEN - 1));

  assign in_ready  = ~rst & (state_q == ST_ACCUM) & ~clear;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_HOLD);
  assign res_sum   = res_sum_q;
  assign res_max   = res_max_q;
  assign res_ovf   = res_ovf_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    ovf_d     = ovf_q;
    res_sum_d = res_sum_q;
    res_max_d = res_max_q;
    res_ovf_d = res_ovf_q;
    case (state_q)
      ST_ACCUM: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          max_d = '0;
          ovf_d = 1'b0;
        end else if (accept) begin
          if (last) begin
            res_sum_d = acc_next;
            res_max_d = max_next;
            res_ovf_d = ovf_q | step_ovf;
            acc_d     = '0;
            cnt_d     = '0;
            max_d     = '0;
            ovf_d     = 1'b0;
            state_d   = ST_HOLD;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + 1'b1;
            max_d = max_next;
            ovf_d = ovf_q | step_ovf;
          end
        end
      end
      ST_HOLD: begin
        // An abort via clear leaves res_* untouched, same as a normal handshake.
        if (clear || out_ready) begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      max_q     <= '0;
      ovf_q     <= 1'b0;
      res_sum_q <= '0;
      res_max_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      ovf_q     <= ovf_d;
      res_sum_q <= res_sum_d;
      res_max_q <= res_max_d;
      res_ovf_q <= res_ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arith_result_acc.sv
// tb_arith_result_acc: directed + randomized checks of arith_result_acc against a
// block-level model (queue of samples, summary computed when the block closes).
`default_nettype none

module tb_arith_result_acc;

  localparam int RES_W     = 5;
  localparam int ACC_W     = 8;
  localparam int BLOCK_LEN = 4;
  localparam int CNT_W     = 8;
  localparam int MAXV      = (1 << ACC_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] x, y, u, z, v;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] res_sum;
  logic [RES_W-1:0] res_max;
  logic             res_ovf;

  arith_result_acc #(
    .RES_W(RES_W), .ACC_W(ACC_W), .BLOCK_LEN(BLOCK_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .u(u), .z(z), .v(v), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_sum(res_sum), .res_max(res_max), .res_ovf(res_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: samples of the open block, plus the last published summary.
  int q_sum[$];
  int q_x[$];
  bit m_hold;
  int m_res_sum, m_res_max;
  bit m_res_ovf;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_sum.delete();
    q_x.delete();
    m_hold = 1'b0;
    m_res_sum = 0;
    m_res_max = 0;
    m_res_ovf = 1'b0;
  endtask

  task automatic close_block();
    int total = 0;
    int mx = 0;
    foreach (q_sum[i]) total += q_sum[i];
    foreach (q_x[i]) if (q_x[i] > mx) mx = q_x[i];
    m_res_ovf = (total > MAXV);
`ifdef ACC_SAT_EN
    m_res_sum = (total > MAXV) ? MAXV : total;
`else
    m_res_sum = total % (MAXV + 1);
`endif
    m_res_max = mx;
    q_sum.delete();
    q_x.delete();
    m_hold = 1'b1;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_hold) begin
      if (clear || out_ready) m_hold = 1'b0;
    end else if (clear) begin
      q_sum.delete();
      q_x.delete();
    end else if (in_valid) begin
      q_sum.push_back(int'(x) + int'(y) + int'(u) + int'(z) + int'(v));
      q_x.push_back(int'(x));
      if (q_sum.size() == BLOCK_LEN) close_block();
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  int'(in_ready),  int'(!rst && !m_hold && !clear));
      chk("out_valid", int'(out_valid), int'(m_hold));
      chk("res_sum",   int'(res_sum),   m_res_sum);
      chk("res_max",   int'(res_max),   m_res_max);
      chk("res_ovf",   int'(res_ovf),   int'(m_res_ovf));
    end
  end

  task automatic step(input logic iv, input logic [RES_W-1:0] a, b, c, d, e,
                      input logic clr, input logic ordy, input logic r);
    in_valid = iv; x = a; y = b; u = c; z = d; v = e;
    clear = clr; out_ready = ordy; rst = r;
    if (r) model_reset();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; u = '0; z = '0; v = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_res_sum", int'(res_sum), 0);

    idle(1'b0);
    chk("post_rst_in_ready", int'(in_ready), 1);

    // All ones, four samples.
    repeat (4) step(1'b1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 1'b0, 1'b1, 1'b0);
    chk("t2_valid", int'(out_valid), 1);
    chk("t2_sum", int'(res_sum), 20);
    chk("t2_max", int'(res_max), 1);
    chk("t2_ovf", int'(res_ovf), 0);
    idle(1'b1);

    // Max tracking with stalled consumer.
    step(1'b1, 5'd3,  5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd8,  5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd5,  5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd12, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t3_sum", int'(res_sum), 28);
    chk("t3_max", int'(res_max), 12);
    repeat (5) step(1'b1, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);
    chk("t3_hold_valid", int'(out_valid), 1);
    chk("t3_hold_sum", int'(res_sum), 28);
    idle(1'b1);

    // Overflow of the 8-bit accumulator: 4 * 155 = 620.
    repeat (4) step(1'b1, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0);
`ifdef ACC_SAT_EN
    chk("t4_sum", int'(res_sum), 255);
`else
    chk("t4_sum", int'(res_sum), 108);
`endif
    chk("t4_ovf", int'(res_ovf), 1);
    idle(1'b1);

    // Clear mid-block; the clear-cycle sample is dropped.
    repeat (2) step(1'b1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0);
    chk("t5_sum", int'(res_sum), 20);
    chk("t5_ovf", int'(res_ovf), 0);

    // Asynchronous reset while holding a result.
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_async_valid", int'(out_valid), 0);
    chk("t6_async_sum", int'(res_sum), 0);
    step(1'b1, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t6_partial_valid", int'(out_valid), 0);
    step(1'b1, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t6_new_valid", int'(out_valid), 1);
    chk("t6_new_sum", int'(res_sum), 18);
    chk("t6_new_max", int'(res_max), 6);
    idle(1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 99) == 0));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
